seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the core.
- Runs IDLE → FETCH → EXEC → UPDATE:
  - fetches instructions from instruction memory over a req/ack handshake,
  - starts the execute unit and waits for its completion,
  - updates the PC.
- Adds over the plain run/halt state machine: single-step, branch redirect, fetch-timeout fault, and a retired-instruction counter.

Parameters:
- AW, 8: PC / instruction-address width.
- DW, 16: instruction width.
- TMO, 15: maximum cycles in FETCH without imem_ack before fault. Must be ≥1.
- CW, 16: retired-counter width.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- run, in, 1: start continuous execution (sampled in IDLE).
- step, in, 1: execute exactly one instruction (sampled in IDLE).
- halt, in, 1: stop after the current instruction completes.
- imem_req, out, 1: fetch request.
- imem_addr, out, AW: fetch address (= pc).
- imem_ack, in, 1: fetch data valid.
- imem_rdata, in, DW: fetched instruction.
- ir, out, DW: instruction register.
- exec_start, out, 1: one-cycle pulse that starts the execute unit.
- exec_done, in, 1: execute complete.
- br_taken, in, 1: branch taken, valid with exec_done.
- br_target, in, AW: branch target, valid with exec_done.
- pc, out, AW: program counter.
- cs, out, 2: current state.
- busy, out, 1: cs != IDLE.
- fault, out, 1: sticky fetch-timeout flag.
- retired, out, CW: count of completed instructions.

Behaviour:
- Reset is asynchronous and active-low on reset; clock is clk. All state updates on the rising edge of clk.
- Reset values: cs=IDLE, pc=0, ir=0, imem_req=0, exec_start=0, fault=0, retired=0, busy=0; internal halt_pend=0, step_mode=0, timer=0.
- Reset asserted mid-operation: imem_req and exec_start drop immediately; any in-flight ack or done is discarded.
- State encoding: IDLE=2'b00, FETCH=2'b01, EXEC=2'b10, UPDATE=2'b11.
- IDLE:
  - halt=1 blocks any start.
  - Else run=1 → FETCH with step_mode=0; run has priority over step.
  - Else step=1 → FETCH with step_mode=1.
  - Accepting a start clears fault and halt_pend.
- FETCH:
  - imem_req=1 and imem_addr=pc combinationally while cs==FETCH.
  - On imem_ack: ir<=imem_rdata, go to EXEC. imem_req deasserts in the following cycle.
  - timer counts the cycles spent in FETCH without ack. If the TMO-th such cycle passes with no ack: fault<=1, go to IDLE; pc and ir are unchanged.
  - An ack arriving in the same cycle as timer==TMO-1 is accepted; a successful fetch takes precedence over the timeout.
  - timer clears on leaving FETCH.
- EXEC:
  - exec_start=1 only in the first cycle of EXEC, registered on FETCH→EXEC.
  - exec_done is ignored in that start cycle and honoured from the next cycle on.
  - No timeout in EXEC.
  - On exec_done: capture br_taken/br_target, go to UPDATE.
- UPDATE (exactly one cycle):
  - pc <= br_taken ? br_target : pc+1, modulo 2^AW (pc wraps from all-ones to 0).
  - retired <= retired+1, wrapping modulo 2^CW.
  - If halt_pend or step_mode, or halt=1 in this cycle → IDLE; else → FETCH.
- halt_pend:
  - Set whenever halt=1 while cs != IDLE.
  - Never aborts a fetch or exec in progress.
  - Cleared on entering IDLE.
- Minimum instruction time with ack in the first FETCH cycle and done in the first eligible EXEC cycle: 4 cycles (FETCH, EXEC start, EXEC done, UPDATE).
- run/step held high continuously: each return to IDLE restarts on the next cycle unless halt=1.

Decomposition:
- Shared package `seq_pkg` holds the state encodings S_IDLE/S_FETCH/S_EXEC/S_UPDATE and the 2-bit state typedef.
- One sub-module, `fetch_wdog`:
  - TMO-parameterised down/up counter with enable=(cs==FETCH && !imem_ack).
  - Clear on exit from FETCH.
  - Output expire.

Test Plan:
- Reset, then run=1 for 1 cycle; ack on the first FETCH cycle with rdata=16'hA5A5; done 1 cycle after start, br_taken=0 → ir=A5A5, exactly one exec_start pulse, pc 0→1, retired=1, second fetch at addr 1.
- Single step: step=1 in IDLE → one instruction executes, pc=1, cs back to IDLE, busy=0, no further imem_req.
- Branch and wrap:
  - pc=8'hFF, br_taken=0 → pc=8'h00.
  - Next instruction with br_taken=1, br_target=8'h40 → next imem_addr=8'h40.
- Halt during EXEC (pulse 1 cycle before done) → UPDATE completes, pc increments, IDLE entered; run held high with halt=1 in IDLE → stays IDLE.
- Fetch timeout:
  - No ack for 15 FETCH cycles → fault=1, cs=IDLE, pc unchanged.
  - Ack exactly at cycle 15 → no fault.
  - A later run clears fault.
- Async reset asserted mid-EXEC → all outputs at reset values immediately, before the next clk edge; a later exec_done is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding for the instruction sequencer.
package seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_EXEC   = 2'b10,
    S_UPDATE = 2'b11
  } state_t;
endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: counts FETCH cycles without ack and flags the TMO-th one.
// Ports: clk, reset (async, active-low), en_i (in FETCH and no ack this cycle),
//        expire_o (the TMO-th unacknowledged FETCH cycle is ending).
module fetch_wdog #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic expire_o
);
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] timer_q, timer_d;
  assign expire_o = en_i && timer_q == TW'(TMO - 1);
  // Dropping en_i means FETCH is being left (or never entered), so the count restarts.
  assign timer_d = (!en_i || expire_o) ? '0 : timer_q + TW'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) timer_q <= '0;
    else timer_q <= timer_d;
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle IDLE/FETCH/EXEC/UPDATE instruction sequencer.
// Ports: clk, reset (async, active-low); run_i/step_i/halt_i control;
//        imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i fetch handshake;
//        exec_start_o/exec_done_i/br_taken_i/br_target_i execute interface;
//        ir_o, pc_o, cs_o, busy_o, fault_o (sticky timeout), retired_o.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int TMO = 15,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          step_i,
  input  logic          halt_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [DW-1:0] ir_o,
  output logic          exec_start_o,
  input  logic          exec_done_i,
  input  logic          br_taken_i,
  input  logic [AW-1:0] br_target_i,
  output logic [AW-1:0] pc_o,
  output logic [1:0]    cs_o,
  output logic          busy_o,
  output logic          fault_o,
  output logic [CW-1:0] retired_o
);
  state_t        cs_q, cs_d;
  logic [AW-1:0] pc_q, pc_d, br_target_q, br_target_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          fault_q, fault_d, step_mode_q, step_mode_d, halt_pend_q, halt_pend_d;
  logic          exec_start_q, exec_start_d, br_taken_q, br_taken_d, expire;

  fetch_wdog #(.TMO(TMO)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .en_i     (cs_q == S_FETCH && !imem_ack_i),
    .expire_o (expire)
  );

  always_comb begin
    cs_d         = cs_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    retired_d    = retired_q;
    fault_d      = fault_q;
    step_mode_d  = step_mode_q;
    halt_pend_d  = halt_pend_q || (halt_i && cs_q != S_IDLE);
    br_taken_d   = br_taken_q;
    br_target_d  = br_target_q;
    exec_start_d = 1'b0;
    case (cs_q)
      S_IDLE:
        if (!halt_i && (run_i || step_i)) begin
          cs_d        = S_FETCH;
          step_mode_d = !run_i;
          fault_d     = 1'b0;
        end
      S_FETCH:
        if (imem_ack_i) begin
          ir_d         = imem_rdata_i;
          cs_d         = S_EXEC;
          exec_start_d = 1'b1;
        end else if (expire) begin
          fault_d = 1'b1;
          cs_d    = S_IDLE;
        end
      // exec_start_q marks the start cycle, in which done is not yet meaningful.
      S_EXEC:
        if (exec_done_i && !exec_start_q) begin
          br_taken_d  = br_taken_i;
          br_target_d = br_target_i;
          cs_d        = S_UPDATE;
        end
      default: begin
        pc_d      = br_taken_q ? br_target_q : pc_q + AW'(1);
        retired_d = retired_q + CW'(1);
        cs_d      = (halt_pend_q || step_mode_q || halt_i) ? S_IDLE : S_FETCH;
      end
    endcase
    if (cs_d == S_IDLE) halt_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cs_q         <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      retired_q    <= '0;
      fault_q      <= 1'b0;
      step_mode_q  <= 1'b0;
      halt_pend_q  <= 1'b0;
      exec_start_q <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      cs_q         <= cs_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      retired_q    <= retired_d;
      fault_q      <= fault_d;
      step_mode_q  <= step_mode_d;
      halt_pend_q  <= halt_pend_d;
      exec_start_q <= exec_start_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
    end

  assign imem_req_o   = cs_q == S_FETCH;
  assign imem_addr_o  = pc_q;
  assign ir_o         = ir_q;
  assign exec_start_o = exec_start_q;
  assign pc_o         = pc_q;
  assign cs_o         = cs_q;
  assign busy_o       = cs_q != S_IDLE;
  assign fault_o      = fault_q;
  assign retired_o    = retired_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: table-driven check of seq_ctrl plus timeout and async-reset sequences.
module tb_seq_ctrl;
  logic        clk = 1'b0, reset = 1'b0;
  logic        run = 1'b0, step = 1'b0, halt = 1'b0, ack = 1'b0, done = 1'b0, bt = 1'b0;
  logic [15:0] rdata = '0, ir, retired;
  logic [7:0]  tgt = '0, addr, pc;
  logic [1:0]  cs;
  logic        req, es, busy, fault;
  int          tests = 0, failed = 0;

  seq_ctrl dut (
    .clk(clk), .reset(reset), .run_i(run), .step_i(step), .halt_i(halt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .ir_o(ir), .exec_start_o(es), .exec_done_i(done), .br_taken_i(bt), .br_target_i(tgt),
    .pc_o(pc), .cs_o(cs), .busy_o(busy), .fault_o(fault), .retired_o(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, h, a; logic [15:0] rd; logic d, b; logic [7:0] t;
    logic [1:0] ecs; logic [7:0] epc; logic [15:0] eir; logic ees; logic [15:0] eret; logic ef;
  } vec_t;

  function automatic vec_t mk(logic r, s, h, a, logic [15:0] rd, logic d, b, logic [7:0] t,
                              logic [1:0] ecs, logic [7:0] epc, logic [15:0] eir, logic ees,
                              logic [15:0] eret, logic ef);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.a = a; v.rd = rd; v.d = d; v.b = b; v.t = t;
    v.ecs = ecs; v.epc = epc; v.eir = eir; v.ees = ees; v.eret = eret; v.ef = ef;
    return v;
  endfunction

  function automatic logic [63:0] obs();
    return {10'd0, cs, pc, ir, es, retired, fault, req, addr, busy};
  endfunction

  function automatic logic [63:0] expv(logic [1:0] c, logic [7:0] p, logic [15:0] i, logic e,
                                       logic [15:0] r, logic f);
    return {10'd0, c, p, i, e, r, f, c == 2'd1, p, c != 2'd0};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] I = 2'd0, F = 2'd1, E = 2'd2, U = 2'd3;
  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk(1,0,0,0,16'h0000,0,0,8'h00, F,8'h00,16'h0000,0,0,0));
    vecs.push_back(mk(0,0,0,1,16'hA5A5,0,0,8'h00, E,8'h00,16'hA5A5,1,0,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0,8'h00, E,8'h00,16'hA5A5,0,0,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0,8'h00, U,8'h00,16'hA5A5,0,0,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, F,8'h01,16'hA5A5,0,1,0));
    vecs.push_back(mk(0,0,1,1,16'h1111,0,0,8'h00, E,8'h01,16'h1111,1,1,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, E,8'h01,16'h1111,0,1,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0,8'h00, U,8'h01,16'h1111,0,1,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, I,8'h02,16'h1111,0,2,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, I,8'h02,16'h1111,0,2,0));
    vecs.push_back(mk(0,1,0,0,16'h0000,0,0,8'h00, F,8'h02,16'h1111,0,2,0));
    vecs.push_back(mk(0,0,0,1,16'h2222,0,0,8'h00, E,8'h02,16'h2222,1,2,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, E,8'h02,16'h2222,0,2,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,1,8'hFF, U,8'h02,16'h2222,0,2,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, I,8'hFF,16'h2222,0,3,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, I,8'hFF,16'h2222,0,3,0));
    vecs.push_back(mk(1,0,0,0,16'h0000,0,0,8'h00, F,8'hFF,16'h2222,0,3,0));
    vecs.push_back(mk(0,0,0,1,16'h3333,0,0,8'h00, E,8'hFF,16'h3333,1,3,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, E,8'hFF,16'h3333,0,3,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0,8'h00, U,8'hFF,16'h3333,0,3,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, F,8'h00,16'h3333,0,4,0));
    vecs.push_back(mk(0,0,0,1,16'h4444,0,0,8'h00, E,8'h00,16'h4444,1,4,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, E,8'h00,16'h4444,0,4,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,1,8'h40, U,8'h00,16'h4444,0,4,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, F,8'h40,16'h4444,0,5,0));
    vecs.push_back(mk(0,0,0,1,16'h5555,0,0,8'h00, E,8'h40,16'h5555,1,5,0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0,8'h00, E,8'h40,16'h5555,0,5,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0,8'h00, U,8'h40,16'h5555,0,5,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, I,8'h41,16'h5555,0,6,0));
    vecs.push_back(mk(1,0,1,0,16'h0000,0,0,8'h00, I,8'h41,16'h5555,0,6,0));
    vecs.push_back(mk(1,0,1,0,16'h0000,0,0,8'h00, I,8'h41,16'h5555,0,6,0));
    vecs.push_back(mk(1,0,0,0,16'h0000,0,0,8'h00, F,8'h41,16'h5555,0,6,0));
    vecs.push_back(mk(0,0,0,1,16'h6666,0,0,8'h00, E,8'h41,16'h6666,1,6,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, E,8'h41,16'h6666,0,6,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0,8'h00, U,8'h41,16'h6666,0,6,0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0,8'h00, I,8'h42,16'h6666,0,7,0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0,8'h00, I,8'h42,16'h6666,0,7,0));

    repeat (2) tick();
    chk("reset_state", obs(), expv(I, 8'h00, 16'h0000, 0, 0, 0));
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run = vecs[i].r; step = vecs[i].s; halt = vecs[i].h; ack = vecs[i].a;
      rdata = vecs[i].rd; done = vecs[i].d; bt = vecs[i].b; tgt = vecs[i].t;
      tick();
      chk($sformatf("vec%0d", i), obs(),
          expv(vecs[i].ecs, vecs[i].epc, vecs[i].eir, vecs[i].ees, vecs[i].eret, vecs[i].ef));
    end
    {run, step, halt, ack, done, bt} = '0;

    // Fetch timeout: 15 unacknowledged FETCH cycles fault; pc/ir untouched.
    run = 1'b1; tick(); run = 1'b0;
    repeat (14) tick();
    chk("tmo_cycle14_still_fetch", obs(), expv(F, 8'h42, 16'h6666, 0, 7, 0));
    tick();
    chk("tmo_fault", obs(), expv(I, 8'h42, 16'h6666, 0, 7, 1));
    tick();
    chk("tmo_fault_sticky", obs(), expv(I, 8'h42, 16'h6666, 0, 7, 1));
    run = 1'b1; tick(); run = 1'b0;
    chk("run_clears_fault", obs(), expv(F, 8'h42, 16'h6666, 0, 7, 0));
    repeat (14) tick();
    ack = 1'b1; rdata = 16'h7777; tick(); ack = 1'b0;
    chk("ack_at_cycle15", obs(), expv(E, 8'h42, 16'h7777, 1, 7, 0));
    halt = 1'b1; tick(); halt = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    chk("late_ack_update", obs(), expv(U, 8'h42, 16'h7777, 0, 7, 0));
    tick();
    chk("late_ack_retire", obs(), expv(I, 8'h43, 16'h7777, 0, 8, 0));

    // Async reset mid-EXEC: outputs clear before any clock edge; done afterwards is ignored.
    run = 1'b1; tick(); run = 1'b0;
    ack = 1'b1; rdata = 16'h8888; tick(); ack = 1'b0;
    chk("pre_reset_exec", obs(), expv(E, 8'h43, 16'h8888, 1, 8, 0));
    #3 reset = 1'b0;
    #1 chk("async_reset", obs(), expv(I, 8'h00, 16'h0000, 0, 0, 0));
    done = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("done_after_reset_ignored", obs(), expv(I, 8'h00, 16'h0000, 0, 0, 0));
    done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
